// File: rtl/dest_ip_tbl_arbiter_if.sv
// Purpose: bundles the host register-side, lookup-side and counter signals of the
//          destination-IP table arbiter so they travel as one port.
// Ports:   master = requester side (host + lookup stage), slave = table owner.
interface dest_ip_tbl_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // host write
    logic          tbl_wr_req;
    logic [AW-1:0] tbl_wr_addr;
    logic [DW-1:0] tbl_wr_data;
    logic          tbl_wr_ack;
    // host read
    logic          tbl_rd_req;
    logic [AW-1:0] tbl_rd_addr;
    logic [DW-1:0] tbl_rd_data;
    logic          tbl_rd_ack;
    // maintenance
    logic          tbl_clear;
    logic [DW-1:0] reset;
    logic          init_done;
    // datapath lookup
    logic          lkp_valid;
    logic [AW-1:0] lkp_addr;
    logic          lkp_ready;
    logic          lkp_rsp_valid;
    logic [DW-1:0] lkp_rsp_data;
    // statistics
    logic [DW-1:0] lkp_grant_count;
    logic [DW-1:0] host_grant_count;
    logic [DW-1:0] host_overrun_count;

    modport master (
        output tbl_wr_req, tbl_wr_addr, tbl_wr_data, tbl_rd_req, tbl_rd_addr,
               tbl_clear, reset, lkp_valid, lkp_addr,
        input  tbl_wr_ack, tbl_rd_data, tbl_rd_ack, init_done, lkp_ready,
               lkp_rsp_valid, lkp_rsp_data, lkp_grant_count, host_grant_count,
               host_overrun_count
    );

    modport slave (
        input  tbl_wr_req, tbl_wr_addr, tbl_wr_data, tbl_rd_req, tbl_rd_addr,
               tbl_clear, reset, lkp_valid, lkp_addr,
        output tbl_wr_ack, tbl_rd_data, tbl_rd_ack, init_done, lkp_ready,
               lkp_rsp_valid, lkp_rsp_data, lkp_grant_count, host_grant_count,
               host_overrun_count
    );
endinterface

// File: rtl/dest_ip_tbl_arbiter.sv
// Purpose: destination-IP table with one access slot shared by host write, host read and lookup.
// Latency: lookup response 1 cycle after accept; host ack 1 cycle after grant (>= 2 after request).
// Backpressure: lkp_ready drops during the init sweep and when the host has waited C_MAX_LKP_BURST lookups.
// Ports: AXI_ACLK clock, AXI_RESETN async active-low reset, bus = dest_ip_tbl_arbiter_if.slave
//        (host wr/rd request-ack, tbl_clear, counter-clear 'reset', lookup valid/ready/response, counters).
module dest_ip_tbl_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_TBL_ADDR_WIDTH   = 5,
    parameter int C_MAX_LKP_BURST    = 8
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_RESETN,
    dest_ip_tbl_arbiter_if.slave  bus
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_TBL_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int SW    = $clog2(C_MAX_LKP_BURST + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  init_ptr, init_ptr_nxt;
    logic [DW-1:0]  tbl_mem [DEPTH];

    logic           wr_pend, rd_pend;
    logic [AW-1:0]  wr_addr_q, rd_addr_q;
    logic [DW-1:0]  wr_data_q;
    logic [SW-1:0]  starve_cnt;

    logic           run, force_host, lkp_rdy, lkp_grant, wr_grant, rd_grant;
    logic           wr_drop, rd_drop;

    logic           wr_ack_q, rd_ack_q, rsp_vld_q;
    logic [DW-1:0]  rd_data_q, rsp_data_q;
    logic [DW-1:0]  lkp_cnt_q, host_cnt_q, ovr_cnt_q;

    // state register
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state    <= S_INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    // next state and grant decode
    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        run          = 1'b0;
        force_host   = 1'b0;
        lkp_rdy      = 1'b0;
        lkp_grant    = 1'b0;
        wr_grant     = 1'b0;
        rd_grant     = 1'b0;
        case (state)
            S_INIT: begin
                if (bus.tbl_clear) begin
                    init_ptr_nxt = '0;
                end else begin
                    init_ptr_nxt = init_ptr + AW'(1);
                    if (init_ptr == {AW{1'b1}}) state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                run = 1'b1;
                // the host has waited a full lookup burst: take the slot away from lookups once
                force_host = (wr_pend | rd_pend) && (starve_cnt == SW'(C_MAX_LKP_BURST));
                lkp_rdy    = ~force_host;
                lkp_grant  = bus.lkp_valid & lkp_rdy;
                wr_grant   = ~lkp_grant & wr_pend;
                rd_grant   = ~lkp_grant & ~wr_pend & rd_pend;
                if (bus.tbl_clear) begin
                    state_nxt    = S_INIT;
                    init_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt    = S_INIT;
                init_ptr_nxt = '0;
            end
        endcase
    end

    // a request is lost only when its slot is occupied and not being vacated this cycle
    assign wr_drop = bus.tbl_wr_req & wr_pend & ~wr_grant;
    assign rd_drop = bus.tbl_rd_req & rd_pend & ~rd_grant;

    // table storage: sweep writes and host writes never coincide (no grants in INIT)
    always_ff @(posedge AXI_ACLK) begin
        if (state == S_INIT)  tbl_mem[init_ptr]  <= '0;
        else if (wr_grant)    tbl_mem[wr_addr_q] <= wr_data_q;
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            starve_cnt <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            lkp_cnt_q  <= '0;
            host_cnt_q <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            if (bus.tbl_wr_req && !wr_drop) begin
                wr_pend   <= 1'b1;
                wr_addr_q <= bus.tbl_wr_addr;
                wr_data_q <= bus.tbl_wr_data;
            end else if (wr_grant) begin
                wr_pend   <= 1'b0;
            end

            if (bus.tbl_rd_req && !rd_drop) begin
                rd_pend   <= 1'b1;
                rd_addr_q <= bus.tbl_rd_addr;
            end else if (rd_grant) begin
                rd_pend   <= 1'b0;
            end

            if (!(wr_pend | rd_pend) || wr_grant || rd_grant)
                starve_cnt <= '0;
            else if (lkp_grant && starve_cnt != SW'(C_MAX_LKP_BURST))
                starve_cnt <= starve_cnt + SW'(1);

            wr_ack_q  <= wr_grant;
            rd_ack_q  <= rd_grant;
            if (rd_grant) rd_data_q <= tbl_mem[rd_addr_q];
            rsp_vld_q <= lkp_grant;
            if (lkp_grant) rsp_data_q <= tbl_mem[bus.lkp_addr];

            if (bus.reset == DW'(1)) begin
                lkp_cnt_q  <= '0;
                host_cnt_q <= '0;
                ovr_cnt_q  <= '0;
            end else begin
                lkp_cnt_q  <= lkp_cnt_q + DW'(lkp_grant);
                host_cnt_q <= host_cnt_q + DW'(wr_grant | rd_grant);
                ovr_cnt_q  <= ovr_cnt_q + DW'(wr_drop) + DW'(rd_drop);
            end
        end
    end

    assign bus.tbl_wr_ack         = wr_ack_q;
    assign bus.tbl_rd_ack         = rd_ack_q;
    assign bus.tbl_rd_data        = rd_data_q;
    assign bus.init_done          = run;
    assign bus.lkp_ready          = lkp_rdy;
    assign bus.lkp_rsp_valid      = rsp_vld_q;
    assign bus.lkp_rsp_data       = rsp_data_q;
    assign bus.lkp_grant_count    = lkp_cnt_q;
    assign bus.host_grant_count   = host_cnt_q;
    assign bus.host_overrun_count = ovr_cnt_q;
endmodule
